burst_forward_arbiter: RTL and testbench
========================================

BURST_FORWARD_ARBITER -- requirements
Module: burst_forward_arbiter

Interface
REQ-001 The block SHALL have parameter MASTERS, default 4, number of requesting masters, legal range 2..16.
REQ-002 The block SHALL have parameter SLAVES, default 4, number of slave destinations, legal range 2..16.
REQ-003 The block SHALL have parameter SLAVE_ID, default 0, this slave's own number, range 0..SLAVES-1.
REQ-004 The block SHALL have parameter LEN_W, default 8, width of the burst-length field.
REQ-005 Derived widths SHALL be MW = $clog2(MASTERS) and SW = $clog2(SLAVES).
REQ-006 The ports SHALL be as follows, clock and reset first:
- ACLK  in  1  single clock; all state updates on its rising edge.
- ARESET  in  1  reset, asynchronous and active-high.
- master_fifo_empty  in  MASTERS  bit i high = master i request FIFO empty.
- master_slave_dest  in  MASTERS*SW  slice i = destination slave of master i head entry.
- master_burst_len  in  MASTERS*LEN_W  slice i = beats-1 of master i head burst (AXI LEN encoding).
- slave_fifo_full  in  1  slave request FIFO cannot accept a push.
- push_to_fifo  out  1  one beat transferred into the slave FIFO this cycle.
- pop_master  out  MASTERS  one-hot; pops the granted master FIFO in the same cycle as push_to_fifo.
- grant_valid  out  1  a master is currently granted.
- grant_master_number  out  MW  index of the granted master; 0 when grant_valid=0.
- burst_active  out  1  the FSM is in state LOCK.

Function
REQ-007 req[i] SHALL equal (~master_fifo_empty[i]) & (master_slave_dest slice i == SLAVE_ID).
REQ-008 The FSM SHALL have exactly two states, IDLE and LOCK.
REQ-009 In IDLE, the grant SHALL go to the first i with req[i]=1, searched from rr_ptr upward modulo MASTERS; grant_valid = |req.
REQ-010 A beat SHALL transfer (push_to_fifo=1, pop_master=onehot(grant)) iff grant_valid & ~slave_fifo_full, combinationally in the same cycle.
REQ-011 In IDLE, a transfer with granted LEN=0 (single beat) SHALL leave the FSM in IDLE and load rr_ptr = (grant+1) mod MASTERS.
REQ-012 In IDLE, a transfer with granted LEN>0 SHALL enter LOCK, latch lock_master=grant, and load beat_cnt=LEN.
REQ-013 In LOCK, the grant SHALL be lock_master only, regardless of other requests and of lock_master's current destination; grant_valid SHALL equal ~master_fifo_empty[lock_master].
REQ-014 In LOCK, each transfer SHALL decrement beat_cnt; the transfer made when beat_cnt==1 is the last beat, and the next state SHALL be IDLE with rr_ptr=(lock_master+1) mod MASTERS.
REQ-015 In LOCK, when lock_master is empty or slave_fifo_full=1, no transfer SHALL occur and beat_cnt, lock_master and state SHALL hold; there is no timeout.
REQ-016 With no grant or slave_fifo_full=1 in IDLE, rr_ptr SHALL hold.
REQ-017 push_to_fifo and slave_fifo_full both high SHALL never occur in the same cycle.
REQ-018 The block SHALL keep no per-beat state beyond beat_cnt (LEN_W bits), lock_master (MW bits), rr_ptr (MW bits) and the state bit.
REQ-019 Total beats pushed for one LEN=N burst SHALL be exactly N+1, contiguous in master order.

Reset
REQ-020 While ARESET=1, the block SHALL force state=IDLE, rr_ptr=0, lock_master=0 and beat_cnt=0 asynchronously.
REQ-021 While ARESET=1, push_to_fifo, pop_master, grant_valid, grant_master_number and burst_active SHALL all be 0, regardless of inputs.
REQ-022 ARESET asserted mid-burst SHALL abandon the burst and, after release, arbitrate from rr_ptr=0 on the first ACLK edge.

Verification (MASTERS=4, SLAVE_ID=1)
REQ-023 The bench SHALL check: masters 0..3 all request dest 1 with LEN=0, slave never full -> grants 0,1,2,3,0 on consecutive cycles with push every cycle.
REQ-024 The bench SHALL check: master 2 LEN=3 and master 3 LEN=0 both requesting, rr_ptr=2 -> master 2 gets 4 contiguous pushes with burst_active=1 on beats 2..4, then master 3, then rr_ptr=0.
REQ-025 The bench SHALL check: slave_fifo_full=1 for 2 cycles mid-burst (beat_cnt=2) -> push=0 and pop_master=0 during the stall, beat_cnt stays 2, and the burst completes afterwards with 4 total beats.
REQ-026 The bench SHALL check: master 1 requests dest 0 and master 0 requests dest 1 -> only master 0 is granted; master 1 is never popped.
REQ-027 The bench SHALL check: ARESET pulsed during LOCK with beat_cnt=5 -> all outputs 0 immediately (asynchronously), and after release the lowest requesting index >= 0 is granted.
REQ-028 The bench SHALL check: in LOCK, lock_master goes empty for 3 cycles while master 3 requests -> grant_valid=0, no pushes, and master 3 is not granted until the burst ends.

Source files
------------

// File: rtl/burst_forward_arbiter.sv
// Burst-aware round-robin arbiter that forwards master FIFO heads into one slave's request FIFO.
// A multi-beat burst keeps the grant on its master until the last beat has been pushed.
module burst_forward_arbiter #(
   parameter  int MASTERS  = 4,
   parameter  int SLAVES   = 4,
   parameter  int SLAVE_ID = 0,
   parameter  int LEN_W    = 8,
   localparam int MW       = $clog2(MASTERS),
   localparam int SW       = $clog2(SLAVES)
) (
   input  logic                     ACLK,
   input  logic                     ARESET,
   input  logic [MASTERS-1:0]       master_fifo_empty,
   input  logic [MASTERS*SW-1:0]    master_slave_dest,
   input  logic [MASTERS*LEN_W-1:0] master_burst_len,
   input  logic                     slave_fifo_full,
   output logic                     push_to_fifo,
   output logic [MASTERS-1:0]       pop_master,
   output logic                     grant_valid,
   output logic [MW-1:0]            grant_master_number,
   output logic                     burst_active
);

   localparam logic [0:0]    ST_IDLE = 1'b0;
   localparam logic [0:0]    ST_LOCK = 1'b1;
   localparam logic [MW-1:0] LAST_M  = MW'(MASTERS - 1);
   localparam logic [SW-1:0] OWN_ID  = SW'(SLAVE_ID);

   logic [0:0]       state_q, state_d;
   logic [MW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [MW-1:0]    lock_master_q, lock_master_d;
   logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;

   logic [MASTERS-1:0] req;
   logic [MW-1:0]      rr_grant;
   logic               rr_found;
   logic [MW-1:0]      grant;
   logic               grant_any;
   logic               transfer;
   logic [LEN_W-1:0]   grant_len;

   function automatic logic [MW-1:0] next_ptr(input logic [MW-1:0] m);
      return (m == LAST_M) ? '0 : m + MW'(1);
   endfunction

   // NOTE: every signal driven in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      req = '0;
      for (int i = 0; i < MASTERS; i++) begin
         req[i] = ~master_fifo_empty[i] & (master_slave_dest[i*SW +: SW] == OWN_ID);
      end
   end

   always_comb begin
      int idx;
      rr_grant = '0;
      rr_found = 1'b0;
      idx      = 0;
      for (int k = 0; k < MASTERS; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= MASTERS) idx = idx - MASTERS;
         if (!rr_found && req[idx]) begin
            rr_found = 1'b1;
            rr_grant = MW'(idx);
         end
      end
   end

   // A locked burst follows its master only; its destination and other requests are ignored.
   always_comb begin
      grant     = '0;
      grant_any = 1'b0;
      if (!ARESET) begin
         if (state_q == ST_LOCK) begin
            grant     = lock_master_q;
            grant_any = ~master_fifo_empty[lock_master_q];
         end else begin
            grant     = rr_grant;
            grant_any = rr_found;
         end
      end
   end

   assign transfer            = grant_any & ~slave_fifo_full;
   assign grant_len           = master_burst_len[grant*LEN_W +: LEN_W];
   assign push_to_fifo        = transfer;
   assign grant_valid         = grant_any;
   assign grant_master_number = grant_any ? grant : '0;
   assign burst_active        = ~ARESET & (state_q == ST_LOCK);

   always_comb begin
      pop_master = '0;
      if (transfer) pop_master[grant] = 1'b1;
   end

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      lock_master_d = lock_master_q;
      beat_cnt_d    = beat_cnt_q;
      if (transfer) begin
         if (state_q == ST_IDLE) begin
            if (grant_len == '0) begin
               rr_ptr_d = next_ptr(grant);
            end else begin
               state_d       = ST_LOCK;
               lock_master_d = grant;
               beat_cnt_d    = grant_len;
            end
         end else begin
            beat_cnt_d = beat_cnt_q - LEN_W'(1);
            if (beat_cnt_q == LEN_W'(1)) begin
               state_d  = ST_IDLE;
               rr_ptr_d = next_ptr(lock_master_q);
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update together from pre-edge values.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q       <= ST_IDLE;
         rr_ptr_q      <= '0;
         lock_master_q <= '0;
         beat_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         lock_master_q <= lock_master_d;
         beat_cnt_q    <= beat_cnt_d;
      end
   end

endmodule

// File: tb/tb_burst_forward_arbiter.sv
// Self-checking bench for burst_forward_arbiter: directed scenarios plus randomized traffic
// compared against a burst-level reference model driven by modelled master FIFOs.
`timescale 1ns/1ps
module tb_burst_forward_arbiter;

   localparam int M     = 4;
   localparam int S     = 4;
   localparam int SID   = 1;
   localparam int LW    = 8;
   localparam int DEPTH = 16;

   logic            ACLK = 1'b0;
   logic            ARESET;
   logic [M-1:0]    master_fifo_empty;
   logic [M*2-1:0]  master_slave_dest;
   logic [M*LW-1:0] master_burst_len;
   logic            slave_fifo_full;
   logic            push_to_fifo;
   logic [M-1:0]    pop_master;
   logic            grant_valid;
   logic [1:0]      grant_master_number;
   logic            burst_active;

   int total = 0;
   int bad   = 0;

   // master FIFOs hold whole bursts; used[] counts beats already popped from the head burst
   int b_dest [M][DEPTH];
   int b_len  [M][DEPTH];
   int rd [M];
   int wr [M];
   int used [M];
   bit hold [M];
   bit full;
   bit drv_empty [M];
   int drv_dest [M];
   int drv_len [M];

   // reference model: current owner of the slave (-1 none), beats still owed, round-robin start
   int         m_owner;
   int         m_left;
   int         m_rr;
   int         exp_g;
   bit         exp_push;
   bit         exp_gv;
   bit         exp_ba;
   logic [M-1:0] exp_pop;

   burst_forward_arbiter #(.MASTERS(M), .SLAVES(S), .SLAVE_ID(SID), .LEN_W(LW)) dut (
      .ACLK                (ACLK),
      .ARESET              (ARESET),
      .master_fifo_empty   (master_fifo_empty),
      .master_slave_dest   (master_slave_dest),
      .master_burst_len    (master_burst_len),
      .slave_fifo_full     (slave_fifo_full),
      .push_to_fifo        (push_to_fifo),
      .pop_master          (pop_master),
      .grant_valid         (grant_valid),
      .grant_master_number (grant_master_number),
      .burst_active        (burst_active)
   );

   always #5 ACLK = ~ACLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [8:0] obs();
      return {push_to_fifo, pop_master, grant_valid, grant_master_number, burst_active};
   endfunction

   function automatic logic [8:0] expv();
      return {exp_push, exp_pop, exp_gv, 2'(exp_gv ? exp_g : 0), exp_ba};
   endfunction

   task automatic add_burst(input int m, input int dest, input int len);
      b_dest[m][wr[m] % DEPTH] = dest;
      b_len[m][wr[m] % DEPTH]  = len;
      wr[m]++;
   endtask

   task automatic env_clear();
      for (int m = 0; m < M; m++) begin
         rd[m] = 0; wr[m] = 0; used[m] = 0; hold[m] = 1'b0;
      end
      full = 1'b0;
   endtask

   task automatic model_clear();
      m_owner = -1; m_left = 0; m_rr = 0;
   endtask

   task automatic env_apply();
      for (int m = 0; m < M; m++) begin
         drv_empty[m] = (rd[m] == wr[m]) || hold[m];
         if (!drv_empty[m]) begin
            drv_dest[m] = b_dest[m][rd[m] % DEPTH];
            drv_len[m]  = b_len[m][rd[m] % DEPTH];
         end else begin
            drv_dest[m] = $urandom_range(0, S-1);
            drv_len[m]  = $urandom_range(0, 255);
         end
         master_fifo_empty[m]       = drv_empty[m];
         master_slave_dest[m*2 +: 2] = 2'(drv_dest[m]);
         master_burst_len[m*LW +: LW] = 8'(drv_len[m]);
      end
      slave_fifo_full = full;
   endtask

   task automatic model_predict();
      exp_g = -1;
      if (ARESET !== 1'b1) begin
         if (m_owner >= 0) begin
            if (!drv_empty[m_owner]) exp_g = m_owner;
         end else begin
            for (int k = 0; k < M; k++) begin
               int i;
               i = (m_rr + k) % M;
               if (exp_g < 0 && !drv_empty[i] && drv_dest[i] == SID) exp_g = i;
            end
         end
      end
      exp_gv   = (exp_g >= 0);
      exp_push = exp_gv && !full;
      exp_pop  = '0;
      if (exp_push) exp_pop[exp_g] = 1'b1;
      exp_ba   = (ARESET !== 1'b1) && (m_owner >= 0);
   endtask

   task automatic model_commit();
      if (exp_push) begin
         if (m_owner < 0) begin
            m_owner = exp_g;
            m_left  = drv_len[exp_g] + 1;
         end
         m_left--;
         if (m_left == 0) begin
            m_rr    = (m_owner + 1) % M;
            m_owner = -1;
         end
         used[exp_g]++;
         if (used[exp_g] == b_len[exp_g][rd[exp_g] % DEPTH] + 1) begin
            rd[exp_g]++;
            used[exp_g] = 0;
         end
      end
   endtask

   task automatic settle();
      env_apply();
      @(negedge ACLK);
      model_predict();
   endtask

   task automatic advance();
      @(posedge ACLK);
      #1;
      model_commit();
   endtask

   task automatic apply_reset();
      ARESET = 1'b1;
      env_clear();
      model_clear();
      env_apply();
      repeat (2) @(posedge ACLK);
      #1 ARESET = 1'b0;
   endtask

   task automatic test_reset();
      ARESET = 1'b1;
      env_clear();
      model_clear();
      for (int m = 0; m < M; m++) add_burst(m, SID, 2);
      env_apply();
      @(negedge ACLK);
      if (obs() !== 9'b0) begin
         bad++; $display("FAIL reset_outputs: got=%b want=%b", obs(), 9'b0);
      end
      total++;
      @(posedge ACLK);
      #1 ARESET = 1'b0;
      for (int c = 0; c < 4; c++) begin
         settle();
         if (obs() !== expv()) begin
            bad++; $display("FAIL reset_release c=%0d: got=%b want=%b", c, obs(), expv());
         end
         total++;
         if (c == 0 && (grant_master_number !== 2'd0 || push_to_fifo !== 1'b1)) begin
            bad++; $display("FAIL reset_first_grant: got gm=%0d push=%b want gm=0 push=1", grant_master_number, push_to_fifo);
         end
         if (c == 0) total++;
         advance();
      end
   endtask

   task automatic test_round_robin();
      int seq [5];
      seq = '{0, 1, 2, 3, 0};
      apply_reset();
      for (int m = 0; m < M; m++) begin
         add_burst(m, SID, 0);
         add_burst(m, SID, 0);
      end
      for (int c = 0; c < 5; c++) begin
         settle();
         if (obs() !== expv()) begin
            bad++; $display("FAIL rr_model c=%0d: got=%b want=%b", c, obs(), expv());
         end
         if (grant_master_number !== 2'(seq[c]) || push_to_fifo !== 1'b1) begin
            bad++; $display("FAIL rr_order c=%0d: got gm=%0d push=%b want gm=%0d push=1", c, grant_master_number, push_to_fifo, seq[c]);
         end
         total += 2;
         advance();
      end
   endtask

   task automatic test_burst_lock();
      int gm_t [7];
      bit ba_t [7];
      gm_t = '{1, 2, 2, 2, 2, 3, 0};
      ba_t = '{0, 0, 1, 1, 1, 0, 0};
      apply_reset();
      add_burst(1, SID, 0);
      add_burst(2, SID, 3);
      add_burst(3, SID, 0);
      for (int c = 0; c < 7; c++) begin
         if (c == 6) begin
            add_burst(0, SID, 0);
            add_burst(3, SID, 0);
         end
         settle();
         if (obs() !== expv()) begin
            bad++; $display("FAIL lock_model c=%0d: got=%b want=%b", c, obs(), expv());
         end
         if ({push_to_fifo, grant_master_number, burst_active} !== {1'b1, 2'(gm_t[c]), ba_t[c]}) begin
            bad++; $display("FAIL lock_sequence c=%0d: got push=%b gm=%0d ba=%b want push=1 gm=%0d ba=%b",
                            c, push_to_fifo, grant_master_number, burst_active, gm_t[c], ba_t[c]);
         end
         total += 2;
         advance();
      end
   endtask

   task automatic test_stall();
      bit push_t [7];
      bit full_t [7];
      bit gv_t [7];
      bit ba_t [7];
      int pushes;
      push_t = '{1, 1, 0, 0, 1, 1, 0};
      full_t = '{0, 0, 1, 1, 0, 0, 0};
      gv_t   = '{1, 1, 1, 1, 1, 1, 0};
      ba_t   = '{0, 1, 1, 1, 1, 1, 0};
      pushes = 0;
      apply_reset();
      add_burst(0, SID, 3);
      for (int c = 0; c < 7; c++) begin
         full = full_t[c];
         settle();
         if (push_to_fifo === 1'b1) pushes++;
         if (obs() !== expv()) begin
            bad++; $display("FAIL stall_model c=%0d: got=%b want=%b", c, obs(), expv());
         end
         if ({push_to_fifo, pop_master, grant_valid, burst_active} !==
             {push_t[c], (push_t[c] ? 4'b0001 : 4'b0000), gv_t[c], ba_t[c]}) begin
            bad++; $display("FAIL stall_beats c=%0d: got push=%b pop=%b gv=%b ba=%b want push=%b gv=%b ba=%b",
                            c, push_to_fifo, pop_master, grant_valid, burst_active, push_t[c], gv_t[c], ba_t[c]);
         end
         total += 2;
         advance();
      end
      full = 1'b0;
      if (pushes != 4) begin
         bad++; $display("FAIL stall_total_beats: got %0d want 4", pushes);
      end
      total++;
   endtask

   task automatic test_dest_filter();
      bit gv_t [4];
      gv_t = '{1, 1, 0, 0};
      apply_reset();
      add_burst(1, 0, 0);
      add_burst(1, 0, 0);
      add_burst(0, SID, 0);
      add_burst(0, SID, 0);
      for (int c = 0; c < 4; c++) begin
         settle();
         if (obs() !== expv()) begin
            bad++; $display("FAIL filter_model c=%0d: got=%b want=%b", c, obs(), expv());
         end
         if (pop_master[1] !== 1'b0 || grant_valid !== gv_t[c] || grant_master_number !== 2'd0) begin
            bad++; $display("FAIL filter_grant c=%0d: got pop=%b gv=%b gm=%0d want pop[1]=0 gv=%b gm=0",
                            c, pop_master, grant_valid, grant_master_number, gv_t[c]);
         end
         total += 2;
         advance();
      end
   endtask

   task automatic test_async_reset();
      int lo;
      apply_reset();
      add_burst(2, SID, 7);
      for (int c = 0; c < 3; c++) begin
         settle();
         if (obs() !== expv()) begin
            bad++; $display("FAIL areset_pre c=%0d: got=%b want=%b", c, obs(), expv());
         end
         total++;
         advance();
      end
      env_apply();
      #1;
      if (burst_active !== 1'b1 || grant_valid !== 1'b1) begin
         bad++; $display("FAIL areset_in_lock: got ba=%b gv=%b want ba=1 gv=1", burst_active, grant_valid);
      end
      total++;
      #1 ARESET = 1'b1;
      model_clear();
      #1;
      if (obs() !== 9'b0) begin
         bad++; $display("FAIL areset_immediate: got=%b want=%b", obs(), 9'b0);
      end
      total++;
      env_clear();
      add_burst(1, SID, 0);
      add_burst(3, SID, 0);
      env_apply();
      @(posedge ACLK);
      #1;
      if (obs() !== 9'b0) begin
         bad++; $display("FAIL areset_held: got=%b want=%b", obs(), 9'b0);
      end
      total++;
      ARESET = 1'b0;
      for (int c = 0; c < 2; c++) begin
         settle();
         lo = -1;
         for (int m = 0; m < M; m++) if (lo < 0 && !drv_empty[m] && drv_dest[m] == SID) lo = m;
         if (obs() !== expv()) begin
            bad++; $display("FAIL areset_after c=%0d: got=%b want=%b", c, obs(), expv());
         end
         total++;
         if (c == 0) begin
            if (grant_valid !== 1'b1 || grant_master_number !== 2'(lo)) begin
               bad++; $display("FAIL areset_lowest: got gv=%b gm=%0d want gv=1 gm=%0d", grant_valid, grant_master_number, lo);
            end
            total++;
         end
         advance();
      end
   endtask

   task automatic test_lock_empty();
      int gm_t [8];
      bit gv_t [8];
      bit ba_t [8];
      gm_t = '{1, 1, 0, 0, 0, 1, 1, 3};
      gv_t = '{1, 1, 0, 0, 0, 1, 1, 1};
      ba_t = '{0, 1, 1, 1, 1, 1, 1, 0};
      apply_reset();
      add_burst(1, SID, 3);
      add_burst(3, SID, 0);
      for (int c = 0; c < 8; c++) begin
         hold[1] = (c >= 2 && c <= 4);
         settle();
         if (obs() !== expv()) begin
            bad++; $display("FAIL empty_model c=%0d: got=%b want=%b", c, obs(), expv());
         end
         if ({push_to_fifo, grant_valid, grant_master_number, burst_active} !==
             {gv_t[c], gv_t[c], 2'(gm_t[c]), ba_t[c]}) begin
            bad++; $display("FAIL empty_lock c=%0d: got push=%b gv=%b gm=%0d ba=%b want push=%b gv=%b gm=%0d ba=%b",
                            c, push_to_fifo, grant_valid, grant_master_number, burst_active, gv_t[c], gv_t[c], gm_t[c], ba_t[c]);
         end
         total += 2;
         advance();
      end
      hold[1] = 1'b0;
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 600; c++) begin
         for (int m = 0; m < M; m++) begin
            if ($urandom_range(0, 99) < 15 && (wr[m] - rd[m]) < DEPTH - 1)
               add_burst(m, ($urandom_range(0, 1) == 1) ? SID : int'($urandom_range(0, S-1)), $urandom_range(0, 5));
            hold[m] = ($urandom_range(0, 9) == 0);
         end
         full = ($urandom_range(0, 3) == 0);
         settle();
         if (obs() !== expv()) begin
            bad++; $display("FAIL random c=%0d: got=%b want=%b", c, obs(), expv());
         end
         total++;
         advance();
         // bursts for other slaves drain as their own arbiters would take them
         for (int m = 0; m < M; m++) begin
            if (m != m_owner && used[m] == 0 && rd[m] != wr[m] &&
                b_dest[m][rd[m] % DEPTH] != SID && $urandom_range(0, 3) == 0)
               rd[m]++;
         end
      end
      full = 1'b0;
      for (int m = 0; m < M; m++) hold[m] = 1'b0;
   endtask

   initial begin
      ARESET = 1'b1;
      env_clear();
      model_clear();
      env_apply();
      test_reset();
      test_round_robin();
      test_burst_lock();
      test_stall();
      test_dest_filter();
      test_async_reset();
      test_lock_empty();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
